// File: rtl/riscv_bus_pkg.sv
// Shared types for the two-master memory bus arbiter.
package riscv_bus_pkg;

    typedef enum logic {IDLE, BUSY} state_e;

    typedef logic owner_t;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_req_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: on a tie the port that did not win last time is granted.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       any
);

    always_comb begin
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
        any    = |req;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one native-protocol memory bus between two masters, one transaction per grant,
// with a watchdog that completes transactions the memory never answers.
module mem_bus_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s0_valid,
    input  logic        s0_instr,
    input  logic [31:0] s0_addr,
    input  logic [31:0] s0_wdata,
    input  logic [3:0]  s0_wstrb,
    output logic        s0_ready,
    output logic [31:0] s0_rdata,
    input  logic        s1_valid,
    input  logic        s1_instr,
    input  logic [31:0] s1_addr,
    input  logic [31:0] s1_wdata,
    input  logic [3:0]  s1_wstrb,
    output logic        s1_ready,
    output logic [31:0] s1_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        owner,
    output logic        timeout
);

    // A zero TIMEOUT_CYCLES still needs a legal one-bit counter.
    localparam bit              WD_EN     = TIMEOUT_CYCLES > 0;
    localparam int unsigned     CW        = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]   EXPIRE_AT = WD_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CW-1:0]   CNT_MAX   = '1;

    state_e          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic            last_q, last_d;
    logic [CW-1:0]   count_q, count_d;
    logic            mem_valid_q, mem_valid_d;
    bus_req_t        mem_req_q, mem_req_d;
    bus_req_t        req0, req1;
    logic [1:0]      gnt;
    logic            any;
    logic            owner_valid, done, expire;

    assign req0 = '{instr: s0_instr, addr: s0_addr, wdata: s0_wdata, wstrb: s0_wstrb};
    assign req1 = '{instr: s1_instr, addr: s1_addr, wdata: s1_wdata, wstrb: s1_wstrb};

    rr_arbiter_2 u_rr (
        .req  ({s1_valid, s0_valid}),
        .last (last_q),
        .gnt  (gnt),
        .any  (any)
    );

    // Completion paths; a live request is required so an abandoned master never sees ready.
    always_comb begin
        owner_valid = owner_q ? s1_valid : s0_valid;
        done        = (state_q == BUSY) && owner_valid && mem_ready;
        expire      = WD_EN && (state_q == BUSY) && owner_valid && !mem_ready
                      && (count_q == EXPIRE_AT);
        s0_ready    = (done || expire) && !owner_q;
        s1_ready    = (done || expire) && owner_q;
        s0_rdata    = (expire && !owner_q) ? ERR_RDATA : mem_rdata;
        s1_rdata    = (expire && owner_q) ? ERR_RDATA : mem_rdata;
        timeout     = expire;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        count_d     = count_q;
        mem_valid_d = mem_valid_q;
        mem_req_d   = mem_req_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d     = BUSY;
                    owner_d     = gnt[1];
                    last_d      = gnt[1];
                    count_d     = '0;
                    mem_valid_d = 1'b1;
                    mem_req_d   = gnt[1] ? req1 : req0;
                end
            end
            BUSY: begin
                if (!mem_ready && count_q != CNT_MAX) begin
                    count_d = count_q + 1'b1;
                end
                if (!owner_valid || done || expire) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            count_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_req_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            count_q     <= count_d;
            mem_valid_q <= mem_valid_d;
            mem_req_q   <= mem_req_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_instr = mem_req_q.instr;
    assign mem_addr  = mem_req_q.addr;
    assign mem_wdata = mem_req_q.wdata;
    assign mem_wstrb = mem_req_q.wstrb;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand sequences, random traffic.
module tb_mem_bus_arbiter;

    localparam int unsigned T   = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk, reset;
    logic        s0_valid, s0_instr, s0_ready;
    logic [31:0] s0_addr, s0_wdata, s0_rdata;
    logic [3:0]  s0_wstrb;
    logic        s1_valid, s1_instr, s1_ready;
    logic [31:0] s1_addr, s1_wdata, s1_rdata;
    logic [3:0]  s1_wstrb;
    logic        mem_valid, mem_instr, mem_ready, owner, timeout;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int vectors = 0;
    int miscompares = 0;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .s0_valid(s0_valid), .s0_instr(s0_instr), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s0_wstrb(s0_wstrb), .s0_ready(s0_ready), .s0_rdata(s0_rdata),
        .s1_valid(s1_valid), .s1_instr(s1_instr), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s1_wstrb(s1_wstrb), .s1_ready(s1_ready), .s1_rdata(s1_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .owner(owner), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s0_valid  = 1'b0;
        s1_valid  = 1'b0;
        mem_ready = 1'b0;
        reset     = 1'b0;
        #10;
        reset     = 1'b1;
    endtask

    typedef struct {
        logic        s0v, s1v, mrdy;
        logic [31:0] mrdata;
        logic        e_mv, e_own, e_r0, e_r1;
        logic [31:0] e_addr, e_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic s0v, input logic s1v, input logic mrdy,
                           input logic [31:0] mrdata, input logic e_mv, input logic e_own,
                           input logic e_r0, input logic e_r1, input logic [31:0] e_addr,
                           input logic [31:0] e_rdata);
        vec_t v;
        v.s0v = s0v; v.s1v = s1v; v.mrdy = mrdy; v.mrdata = mrdata;
        v.e_mv = e_mv; v.e_own = e_own; v.e_r0 = e_r0; v.e_r1 = e_r1;
        v.e_addr = e_addr; v.e_rdata = e_rdata;
        vecs.push_back(v);
    endtask

    // Reference model state for random traffic (transaction level: who holds the bus, how long).
    bit          mbusy, mown, mlast;
    int          age;
    bit          rv[2], got[2];
    logic        ri[2];
    logic [31:0] ra[2], rw[2];
    logic [3:0]  rs[2];
    logic        cap_i;
    logic [31:0] cap_a, cap_w;
    logic [3:0]  cap_s;
    logic        ov, done, to, er;
    bit          w;

    initial begin
        reset = 1'b0;
        s0_valid = 0; s0_instr = 0; s0_addr = 0; s0_wdata = 0; s0_wstrb = 0;
        s1_valid = 0; s1_instr = 0; s1_addr = 0; s1_wdata = 0; s1_wstrb = 0;
        mem_ready = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_mem_valid", mem_valid, 1'b0);
        chk1("rst_owner", owner, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        chk1("rst_s0_ready", s0_ready, 1'b0);
        chk1("rst_s1_ready", s1_ready, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'h0);
        reset = 1'b1;

        // Fixed request fields for the directed part.
        s0_addr = 32'h100;  s0_wdata = 32'h0;        s0_wstrb = 4'b0000; s0_instr = 1'b1;
        s1_addr = 32'h2000; s1_wdata = 32'hA5A5A5A5; s1_wstrb = 4'b0011; s1_instr = 1'b0;

        //       s0v s1v rdy rdata         mv own r0 r1 addr      rdata
        add_vec(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    32'h0);
        add_vec(1, 0, 0, 32'h0,        1, 0, 0, 0, 32'h100,  32'h0);
        add_vec(1, 0, 0, 32'h0,        1, 0, 0, 0, 32'h100,  32'h0);
        add_vec(1, 0, 1, 32'h12345678, 1, 0, 1, 0, 32'h100,  32'h12345678);
        add_vec(0, 1, 0, 32'h0,        0, 0, 0, 0, 32'h100,  32'h0);
        add_vec(0, 1, 0, 32'h0,        1, 1, 0, 0, 32'h2000, 32'h0);
        add_vec(0, 1, 0, 32'h0,        1, 1, 0, 0, 32'h2000, 32'h0);
        add_vec(0, 1, 1, 32'h0BADF00D, 1, 1, 0, 1, 32'h2000, 32'h0BADF00D);
        add_vec(1, 1, 0, 32'h0,        0, 1, 0, 0, 32'h2000, 32'h0);
        add_vec(1, 1, 1, 32'h11111111, 1, 0, 1, 0, 32'h100,  32'h11111111);
        add_vec(1, 1, 0, 32'h0,        0, 0, 0, 0, 32'h100,  32'h0);
        add_vec(1, 1, 1, 32'h22222222, 1, 1, 0, 1, 32'h2000, 32'h22222222);
        add_vec(1, 1, 0, 32'h0,        0, 1, 0, 0, 32'h2000, 32'h0);
        add_vec(1, 1, 1, 32'h33333333, 1, 0, 1, 0, 32'h100,  32'h33333333);
        add_vec(1, 1, 1, 32'h0,        0, 0, 0, 0, 32'h100,  32'h0);
        add_vec(1, 1, 1, 32'h44444444, 1, 1, 0, 1, 32'h2000, 32'h44444444);

        foreach (vecs[i]) begin
            s0_valid = vecs[i].s0v; s1_valid = vecs[i].s1v;
            mem_ready = vecs[i].mrdy; mem_rdata = vecs[i].mrdata;
            #4;
            chk1($sformatf("v%0d_mem_valid", i), mem_valid, vecs[i].e_mv);
            chk1($sformatf("v%0d_owner", i), owner, vecs[i].e_own);
            chk1($sformatf("v%0d_s0_ready", i), s0_ready, vecs[i].e_r0);
            chk1($sformatf("v%0d_s1_ready", i), s1_ready, vecs[i].e_r1);
            chk1($sformatf("v%0d_timeout", i), timeout, 1'b0);
            chk32($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
            if (vecs[i].e_mv) begin
                chk32($sformatf("v%0d_mem_wdata", i), mem_wdata,
                      vecs[i].e_own ? 32'hA5A5A5A5 : 32'h0);
                chk32($sformatf("v%0d_mem_wstrb", i), {28'd0, mem_wstrb},
                      vecs[i].e_own ? 32'h3 : 32'h0);
                chk1($sformatf("v%0d_mem_instr", i), mem_instr, !vecs[i].e_own);
            end
            if (vecs[i].e_r0) chk32($sformatf("v%0d_s0_rdata", i), s0_rdata, vecs[i].e_rdata);
            if (vecs[i].e_r1) chk32($sformatf("v%0d_s1_rdata", i), s1_rdata, vecs[i].e_rdata);
            tick();
        end

        // Watchdog expiry on port 0, then port 1 wins and completes exactly at expiry.
        do_reset();
        s0_valid = 1; s1_valid = 1; mem_ready = 0; mem_rdata = 32'h5555AAAA;
        #4;
        chk1("to_idle_mv", mem_valid, 1'b0);
        tick();
        for (int k = 1; k <= 8; k++) begin
            #4;
            chk1($sformatf("to_k%0d_mv", k), mem_valid, 1'b1);
            chk1($sformatf("to_k%0d_s0_ready", k), s0_ready, k == 8);
            chk1($sformatf("to_k%0d_timeout", k), timeout, k == 8);
            chk1($sformatf("to_k%0d_s1_ready", k), s1_ready, 1'b0);
            if (k == 8) chk32("to_err_rdata", s0_rdata, ERR);
            tick();
        end
        s0_valid = 0;
        #4;
        chk1("to_after_mv", mem_valid, 1'b0);
        chk1("to_after_timeout", timeout, 1'b0);
        tick();
        for (int k = 1; k <= 8; k++) begin
            mem_ready = (k == 8);
            #4;
            chk1($sformatf("race_k%0d_owner", k), owner, 1'b1);
            chk1($sformatf("race_k%0d_s1_ready", k), s1_ready, k == 8);
            chk1($sformatf("race_k%0d_timeout", k), timeout, 1'b0);
            if (k == 8) chk32("race_rdata", s1_rdata, 32'h5555AAAA);
            tick();
        end
        s1_valid = 0; mem_ready = 0;

        // Reset pulled low while the watchdog is firing.
        s0_valid = 1;
        tick();
        repeat (7) tick();
        #1;
        chk1("mid_pre_timeout", timeout, 1'b1);
        chk1("mid_pre_s0_ready", s0_ready, 1'b1);
        reset = 1'b0;
        #1;
        chk1("mid_rst_mv", mem_valid, 1'b0);
        chk1("mid_rst_s0_ready", s0_ready, 1'b0);
        chk1("mid_rst_timeout", timeout, 1'b0);
        tick();
        s1_valid = 1;
        reset = 1'b1;
        #4;
        chk1("post_rst_idle_mv", mem_valid, 1'b0);
        tick();
        #4;
        chk1("post_rst_owner", owner, 1'b0);
        chk1("post_rst_mv", mem_valid, 1'b1);
        chk32("post_rst_addr", mem_addr, 32'h100);

        // Owner abandons its request: no ready, bus released, last stays with port 0.
        tick();
        s0_valid = 0; mem_ready = 1;
        #4;
        chk1("drop_s0_ready", s0_ready, 1'b0);
        chk1("drop_s1_ready", s1_ready, 1'b0);
        chk1("drop_timeout", timeout, 1'b0);
        tick();
        s0_valid = 1; mem_ready = 0;
        #4;
        chk1("drop_idle_mv", mem_valid, 1'b0);
        tick();
        #4;
        chk1("drop_next_owner", owner, 1'b1);
        chk1("drop_next_mv", mem_valid, 1'b1);
        chk32("drop_next_addr", mem_addr, 32'h2000);
        tick();

        // Random protocol-abiding traffic against the transaction-level model.
        do_reset();
        mbusy = 0; mown = 0; mlast = 1; age = 0;
        cap_i = 0; cap_a = 0; cap_w = 0; cap_s = 0;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 0; got[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (rv[i] && got[i]) begin
                    rv[i] = 0;
                end else if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i] = 1;
                    ri[i] = 1'($urandom_range(0, 1));
                    ra[i] = $urandom;
                    rw[i] = $urandom;
                    rs[i] = 4'($urandom_range(0, 15));
                end
            end
            s0_valid = rv[0]; s0_instr = ri[0]; s0_addr = ra[0]; s0_wdata = rw[0];
            s0_wstrb = rs[0];
            s1_valid = rv[1]; s1_instr = ri[1]; s1_addr = ra[1]; s1_wdata = rw[1];
            s1_wstrb = rs[1];
            mem_ready = ($urandom_range(0, 99) < 30);
            mem_rdata = $urandom;
            #4;
            ov   = rv[mown];
            done = mbusy && ov && mem_ready;
            to   = mbusy && ov && !mem_ready && (age == int'(T) - 1);
            er   = done || to;
            chk1("rnd_mem_valid", mem_valid, mbusy);
            chk1("rnd_owner", owner, mown);
            chk1("rnd_mem_instr", mem_instr, cap_i);
            chk32("rnd_mem_addr", mem_addr, cap_a);
            chk32("rnd_mem_wdata", mem_wdata, cap_w);
            chk32("rnd_mem_wstrb", {28'd0, mem_wstrb}, {28'd0, cap_s});
            chk1("rnd_s0_ready", s0_ready, er && !mown);
            chk1("rnd_s1_ready", s1_ready, er && mown);
            chk1("rnd_timeout", timeout, to);
            if (er) chk32("rnd_rdata", mown ? s1_rdata : s0_rdata, to ? ERR : mem_rdata);
            got[0] = er && !mown;
            got[1] = er && mown;
            if (mbusy) begin
                if (!ov || er) mbusy = 0;
                else age++;
            end else if (rv[0] || rv[1]) begin
                w = (rv[0] && rv[1]) ? !mlast : rv[1];
                mbusy = 1; mown = w; mlast = w; age = 0;
                cap_i = ri[w]; cap_a = ra[w]; cap_w = rw[w]; cap_s = rs[w];
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
